// File: rtl/tape_pulse_gen.sv
// Tape pulse generator: each loaded period plays as a half-high/half-low pwm pulse.
// A pending period is consumed one cycle after it is seen, or at the end of LOW with no gap cycle.
// No backpressure: a late load raises sticky underrun, and a second load while one is held raises sticky overrun.
// Optional TAPE_PRESCALE_EN: the timer ticks every PRESCALE clk cycles instead of every cycle.
module tape_pulse_gen #(
    parameter int PRESCALE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_timer,
    input  logic [23:0] timer_val,
    output logic        pwm,
    output logic        busy,
    output logic        underrun,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, PRIME, HIGH, LOW} state_t;

    state_t      state;
    logic [23:0] pending;
    logic        pending_valid;
    logic [23:0] phase_cnt;
    logic [22:0] low_len;
    logic        tick;
    logic        phase_end;
    logic        consume;
    logic [23:0] period;

`ifdef TAPE_PRESCALE_EN
    logic [7:0] div;
    assign tick = (div == 8'(PRESCALE - 1));
`else
    logic unused_prescale;
    assign tick            = 1'b1;
    assign unused_prescale = (PRESCALE != 0);
`endif

    assign busy      = (state == HIGH) || (state == LOW);
    assign phase_end = tick && (phase_cnt == 24'd1);
    assign consume   = pending_valid && ((state == PRIME) || ((state == LOW) && phase_end));
    // Periods below 2 would give an empty phase, so they are stretched to 2.
    assign period    = (pending < 24'd2) ? 24'd2 : pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pwm           <= 1'b1;
            underrun      <= 1'b0;
            overrun       <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            phase_cnt     <= '0;
            low_len       <= '0;
`ifdef TAPE_PRESCALE_EN
            div           <= '0;
`endif
        end else if (!enable) begin
            state         <= IDLE;
            pwm           <= 1'b1;
            pending_valid <= 1'b0;
`ifdef TAPE_PRESCALE_EN
            div           <= '0;
`endif
        end else begin
`ifdef TAPE_PRESCALE_EN
            if (state != IDLE) begin
                div <= tick ? 8'd0 : div + 8'd1;
            end
`endif
            if (consume) begin
                state     <= HIGH;
                pwm       <= 1'b1;
                phase_cnt <= period - {1'b0, period[23:1]};
                low_len   <= period[23:1];
`ifdef TAPE_PRESCALE_EN
                div       <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        state <= PRIME;
                        pwm   <= 1'b0;
                    end
                    HIGH: begin
                        if (phase_end) begin
                            state     <= LOW;
                            pwm       <= 1'b0;
                            phase_cnt <= {1'b0, low_len};
`ifdef TAPE_PRESCALE_EN
                            div       <= '0;
`endif
                        end else if (tick) begin
                            phase_cnt <= phase_cnt - 24'd1;
                        end
                    end
                    LOW: begin
                        if (phase_end) begin
                            state    <= PRIME;
                            underrun <= 1'b1;
                        end else if (tick) begin
                            phase_cnt <= phase_cnt - 24'd1;
                        end
                    end
                    default: ;
                endcase
            end

            // A load in the consuming cycle wins: the new value stays pending.
            if (load_timer && (state != IDLE)) begin
                pending       <= timer_val;
                pending_valid <= 1'b1;
                if (pending_valid && !consume) begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                pending_valid <= 1'b0;
            end
        end
    end
endmodule
